// File: rtl/spatz_vrf_write_arbiter.sv
// -----------------------------------------------------------------------------
// spatz_vrf_write_arbiter
//   Round-robin arbiter that merges several VRF write requesters (VFU, VLSU,
//   VSLDU) onto the single VRF write port through a one-entry output register.
//   The register accepts a new write whenever it is empty or retiring in the
//   same cycle, so the port sustains one write per cycle.
//
//   Optional feature macro: SPATZ_WARB_BYPASS_EN
//     When defined, a grant made while the output register is empty drives the
//     VRF port combinationally in the same cycle. If the VRF accepts it
//     immediately the write completes with zero latency; otherwise it is
//     captured and presented again from the next cycle.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         synchronous active-high reset
//   req_valid_i   per-requester write request
//   req_ready_o   per-requester accept (one-hot, granted index only)
//   req_waddr_i   flattened per-requester word address
//   req_wdata_i   flattened per-requester write data
//   req_wbe_i     flattened per-requester byte enables
//   req_wdone_o   per-requester pulse when its write commits in the VRF
//   vrf_waddr_o   VRF write address
//   vrf_wdata_o   VRF write data
//   vrf_wbe_o     VRF byte enables
//   vrf_we_o      VRF write enable
//   vrf_wvalid_i  VRF accepted the presented write this cycle
// -----------------------------------------------------------------------------
module spatz_vrf_write_arbiter #(
  parameter int unsigned NrRequesters = 3,
  parameter int unsigned AddrWidth    = 7,
  parameter int unsigned DataWidth    = 128
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NrRequesters-1:0]               req_valid_i,
  output logic [NrRequesters-1:0]               req_ready_o,
  input  logic [NrRequesters*AddrWidth-1:0]     req_waddr_i,
  input  logic [NrRequesters*DataWidth-1:0]     req_wdata_i,
  input  logic [NrRequesters*(DataWidth/8)-1:0] req_wbe_i,
  output logic [NrRequesters-1:0]               req_wdone_o,
  output logic [AddrWidth-1:0]                  vrf_waddr_o,
  output logic [DataWidth-1:0]                  vrf_wdata_o,
  output logic [DataWidth/8-1:0]                vrf_wbe_o,
  output logic                                  vrf_we_o,
  input  logic                                  vrf_wvalid_i
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned IdxWidth = (NrRequesters > 1) ? $clog2(NrRequesters) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NrRequesters - 1);

  // Unpacked views of the flattened request buses.
  logic [AddrWidth-1:0] addr_arr [NrRequesters];
  logic [DataWidth-1:0] data_arr [NrRequesters];
  logic [BeWidth-1:0]   be_arr   [NrRequesters];

  for (genvar gi = 0; gi < NrRequesters; gi++) begin : g_unpack
    assign addr_arr[gi] = req_waddr_i[gi*AddrWidth +: AddrWidth];
    assign data_arr[gi] = req_wdata_i[gi*DataWidth +: DataWidth];
    assign be_arr[gi]   = req_wbe_i[gi*BeWidth +: BeWidth];
  end

  // State
  logic [IdxWidth-1:0]  rr_q, rr_d;
  logic                 out_valid_q, out_valid_d;
  logic [AddrWidth-1:0] out_addr_q, out_addr_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic [BeWidth-1:0]   out_be_q, out_be_d;
  logic [IdxWidth-1:0]  out_src_q, out_src_d;

  // Round-robin search: hi_* is the lowest valid index at or above rr_q,
  // lo_* the lowest valid index overall (used when the search wraps).
  logic                hi_found, lo_found;
  logic [IdxWidth-1:0] hi_idx, lo_idx, grant_idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Descending scan so that the last hit is the lowest index.
    for (int i = int'(NrRequesters) - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        lo_found = 1'b1;
        lo_idx   = IdxWidth'(i);
        if (IdxWidth'(i) >= rr_q) begin
          hi_found = 1'b1;
          hi_idx   = IdxWidth'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  logic accept, transfer, retire, bypass, byp_done, capture;

  // Reset gates every handshake so nothing transfers or completes while
  // rst_i is high, including a write pending in the output register.
  assign accept   = ~rst_i & (~out_valid_q | vrf_wvalid_i);
  assign transfer = lo_found & accept;
  assign retire   = out_valid_q & vrf_wvalid_i & ~rst_i;

`ifdef SPATZ_WARB_BYPASS_EN
  assign bypass   = transfer & ~out_valid_q;
  assign byp_done = bypass & vrf_wvalid_i;
`else
  assign bypass   = 1'b0;
  assign byp_done = 1'b0;
`endif

  // A bypassed write that the VRF took immediately never enters the register.
  assign capture = transfer & ~byp_done;

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_be_d    = out_be_q;
    out_src_d   = out_src_q;
    rr_d        = rr_q;
    if (retire) begin
      out_valid_d = 1'b0;
    end
    if (capture) begin
      out_valid_d = 1'b1;
      out_addr_d  = addr_arr[grant_idx];
      out_data_d  = data_arr[grant_idx];
      out_be_d    = be_arr[grant_idx];
      out_src_d   = grant_idx;
    end
    if (transfer) begin
      rr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_be_q    <= '0;
      out_src_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_be_q    <= out_be_d;
      out_src_q   <= out_src_d;
    end
  end

  assign vrf_we_o    = (out_valid_q & ~rst_i) | bypass;
  assign vrf_waddr_o = bypass ? addr_arr[grant_idx] : out_addr_q;
  assign vrf_wdata_o = bypass ? data_arr[grant_idx] : out_data_q;
  assign vrf_wbe_o   = bypass ? be_arr[grant_idx]   : out_be_q;

  for (genvar gi = 0; gi < NrRequesters; gi++) begin : g_resp
    assign req_ready_o[gi] = transfer & (grant_idx == IdxWidth'(gi));
    assign req_wdone_o[gi] = (retire & (out_src_q == IdxWidth'(gi)))
                           | (byp_done & (grant_idx == IdxWidth'(gi)));
  end

endmodule

// File: tb/tb_spatz_vrf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spatz_vrf_write_arbiter
//   Directed bench for spatz_vrf_write_arbiter with the default configuration
//   (3 requesters, 7-bit address, 128-bit data). Expected values are written
//   by hand per scenario; BYP selects the expectations for the bypass build.
// -----------------------------------------------------------------------------
module tb_spatz_vrf_write_arbiter;

`ifdef SPATZ_WARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   valid;
  logic [2:0]   ready;
  logic [6:0]   a [3];
  logic [127:0] d [3];
  logic [15:0]  b [3];
  logic [2:0]   wdone;
  logic [6:0]   vaddr;
  logic [127:0] vdata;
  logic [15:0]  vbe;
  logic         we;
  logic         wvalid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spatz_vrf_write_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (valid),
    .req_ready_o  (ready),
    .req_waddr_i  ({a[2], a[1], a[0]}),
    .req_wdata_i  ({d[2], d[1], d[0]}),
    .req_wbe_i    ({b[2], b[1], b[0]}),
    .req_wdone_o  (wdone),
    .vrf_waddr_o  (vaddr),
    .vrf_wdata_o  (vdata),
    .vrf_wbe_o    (vbe),
    .vrf_we_o     (we),
    .vrf_wvalid_i (wvalid)
  );

  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled 4 time units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic default_reqs();
    for (int i = 0; i < 3; i++) begin
      a[i] = 7'h10 + 7'(i);
      d[i] = {4{32'hC0DE_0000 + 32'(i)}};
      b[i] = 16'hFFFF;
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; valid = 3'b000; wvalid = 1'b0;
    default_reqs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    default_reqs();
    tick();
    rst = 1'b1; valid = 3'b111; wvalid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #4;
      total++; if (ready !== 3'b000) begin bad++; $display("FAIL reset_ready c%0d got=%b exp=000", c, ready); end
      total++; if (we !== 1'b0)      begin bad++; $display("FAIL reset_we c%0d got=%b exp=0", c, we); end
      total++; if (wdone !== 3'b000) begin bad++; $display("FAIL reset_wdone c%0d got=%b exp=000", c, wdone); end
      tick();
    end
    rst = 1'b0;
    #4;
    total++; if (ready !== 3'b001) begin bad++; $display("FAIL release_grant got=%b exp=001", ready); end
    total++; if (wdone !== 3'b000) begin bad++; $display("FAIL release_wdone got=%b exp=000", wdone); end
    total++; if (we !== BYP)       begin bad++; $display("FAIL release_we got=%b exp=%b", we, BYP); end
    $display("test_reset: ready=%b we=%b after release", ready, we);
    tick();
    valid = 3'b000; wvalid = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy, exp_wd;
    logic       exp_we;
    int         src;
    do_reset();
    valid = 3'b111; wvalid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) valid = 3'b000;
      #4;
      exp_rdy = (k < 5) ? (3'b001 << (k % 3)) : 3'b000;
      src     = BYP ? (k % 3) : ((k + 2) % 3);
      exp_we  = BYP ? (k < 5) : (k > 0);
      exp_wd  = exp_we ? (3'b001 << src) : 3'b000;
      total++; if (ready !== exp_rdy) begin bad++; $display("FAIL rr_ready k%0d got=%b exp=%b", k, ready, exp_rdy); end
      total++; if (wdone !== exp_wd)  begin bad++; $display("FAIL rr_wdone k%0d got=%b exp=%b", k, wdone, exp_wd); end
      total++; if (we !== exp_we)     begin bad++; $display("FAIL rr_we k%0d got=%b exp=%b", k, we, exp_we); end
      if (exp_we) begin
        total++; if (vaddr !== a[src]) begin bad++; $display("FAIL rr_addr k%0d got=%h exp=%h", k, vaddr, a[src]); end
      end
      $display("test_round_robin k=%0d ready=%b we=%b wdone=%b addr=%h", k, ready, we, wdone, vaddr);
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    a[1] = 7'h05; d[1] = {16{8'hA5}}; b[1] = 16'hFFFF;
    valid = 3'b010; wvalid = 1'b0;
    #4;
    total++; if (ready !== 3'b010) begin bad++; $display("FAIL bp_grant got=%b exp=010", ready); end
    total++; if (we !== BYP)       begin bad++; $display("FAIL bp_we0 got=%b exp=%b", we, BYP); end
    tick();
    for (int c = 1; c <= 3; c++) begin
      #4;
      total++; if (we !== 1'b1)      begin bad++; $display("FAIL bp_we c%0d got=%b exp=1", c, we); end
      total++; if (vaddr !== 7'h05)  begin bad++; $display("FAIL bp_addr c%0d got=%h exp=05", c, vaddr); end
      total++; if (vdata !== {16{8'hA5}}) begin bad++; $display("FAIL bp_data c%0d got=%h", c, vdata); end
      total++; if (vbe !== 16'hFFFF) begin bad++; $display("FAIL bp_be c%0d got=%h exp=ffff", c, vbe); end
      total++; if (ready !== 3'b000) begin bad++; $display("FAIL bp_ready c%0d got=%b exp=000", c, ready); end
      total++; if (wdone !== 3'b000) begin bad++; $display("FAIL bp_wdone c%0d got=%b exp=000", c, wdone); end
      tick();
    end
    valid = 3'b000; wvalid = 1'b1;
    #4;
    total++; if (wdone !== 3'b010) begin bad++; $display("FAIL bp_release_wdone got=%b exp=010", wdone); end
    tick();
    #4;
    total++; if (wdone !== 3'b000) begin bad++; $display("FAIL bp_single_wdone got=%b exp=000", wdone); end
    total++; if (we !== 1'b0)      begin bad++; $display("FAIL bp_drained_we got=%b exp=0", we); end
    $display("test_backpressure: addr=05 held 3 stalled cycles, wdone on release");
    tick();
  endtask

  task automatic test_zero_be();
    do_reset();
    a[2] = 7'h7F; b[2] = 16'h0000;
    valid = 3'b001; wvalid = 1'b1;      // requester 0 moves rr_ptr to 1
    #4;
    total++; if (ready !== 3'b001) begin bad++; $display("FAIL zbe_first got=%b exp=001", ready); end
    tick();
    valid = 3'b000;                      // drain
    tick();
    valid = 3'b100; wvalid = 1'b0;       // requester 2 captured, rr_ptr wraps
    #4;
    total++; if (ready !== 3'b100) begin bad++; $display("FAIL zbe_grant got=%b exp=100", ready); end
    total++; if (wdone !== 3'b000) begin bad++; $display("FAIL zbe_early_wdone got=%b exp=000", wdone); end
    tick();
    valid = 3'b000; wvalid = 1'b1;
    #4;
    total++; if (we !== 1'b1)      begin bad++; $display("FAIL zbe_we got=%b exp=1", we); end
    total++; if (vaddr !== 7'h7F)  begin bad++; $display("FAIL zbe_addr got=%h exp=7f", vaddr); end
    total++; if (vbe !== 16'h0000) begin bad++; $display("FAIL zbe_be got=%h exp=0000", vbe); end
    total++; if (wdone !== 3'b100) begin bad++; $display("FAIL zbe_wdone got=%b exp=100", wdone); end
    tick();
    valid = 3'b111;
    #4;
    total++; if (ready !== 3'b001) begin bad++; $display("FAIL zbe_rr_wrap got=%b exp=001", ready); end
    total++; if (we !== BYP)       begin bad++; $display("FAIL zbe_after_we got=%b exp=%b", we, BYP); end
    $display("test_zero_be: be=0000 addr=7f forwarded, next grant=%b", ready);
    tick();
    valid = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid = 3'b001; wvalid = 1'b0;
    tick();
    valid = 3'b000;
    #4;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL mid_pending_we got=%b exp=1", we); end
    tick();
    rst = 1'b1; wvalid = 1'b1;
    #4;
    total++; if (wdone !== 3'b000) begin bad++; $display("FAIL mid_rst_wdone got=%b exp=000", wdone); end
    total++; if (we !== 1'b0)      begin bad++; $display("FAIL mid_rst_we got=%b exp=0", we); end
    tick();
    rst = 1'b0;
    #4;
    total++; if (we !== 1'b0)      begin bad++; $display("FAIL mid_after_we got=%b exp=0", we); end
    total++; if (wdone !== 3'b000) begin bad++; $display("FAIL mid_after_wdone got=%b exp=000", wdone); end
    tick();
    valid = 3'b111; wvalid = 1'b0;
    #4;
    total++; if (ready !== 3'b001) begin bad++; $display("FAIL mid_rr_ptr got=%b exp=001", ready); end
    $display("test_reset_mid: pending write dropped, next grant=%b", ready);
    tick();
    valid = 3'b000; wvalid = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_latency();
    logic [2:0] exp_wd0, exp_wd1;
    do_reset();
    valid = 3'b001; wvalid = 1'b1;
    exp_wd0 = BYP ? 3'b001 : 3'b000;
    exp_wd1 = BYP ? 3'b000 : 3'b001;
    #4;
    total++; if (we !== BYP)        begin bad++; $display("FAIL lat_we0 got=%b exp=%b", we, BYP); end
    total++; if (wdone !== exp_wd0) begin bad++; $display("FAIL lat_wdone0 got=%b exp=%b", wdone, exp_wd0); end
    tick();
    valid = 3'b000;
    #4;
    total++; if (we !== !BYP)       begin bad++; $display("FAIL lat_we1 got=%b exp=%b", we, !BYP); end
    total++; if (wdone !== exp_wd1) begin bad++; $display("FAIL lat_wdone1 got=%b exp=%b", wdone, exp_wd1); end
    if (we) begin
      total++; if (vdata !== d[0]) begin bad++; $display("FAIL lat_data got=%h exp=%h", vdata, d[0]); end
    end
    $display("test_latency: write latency %0d cycle(s)", BYP ? 0 : 1);
    tick();
  endtask

  initial begin
    rst = 1'b0; valid = 3'b000; wvalid = 1'b0;
    default_reqs();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_zero_be();
    test_reset_mid();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
